// File: rtl/mips_fetch_queue.sv
// Instruction fetch unit with a small in-order instruction queue toward decode.
// Keeps at most one memory request in flight; redirects flush the queue and drop stale responses.
module mips_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   clk1,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   id_valid,
    output logic [31:0]            id_instr,
    output logic [31:0]            id_npc,
    input  logic                   id_ready,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int            PW     = $clog2(DEPTH);
    localparam logic [PW:0]   FULL   = (PW+1)'(DEPTH);
    localparam logic [5:0]    OP_HLT = 6'b111111;

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]    state;
    logic          discard;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_npc   [DEPTH];
    logic [31:0]   hold_instr;
    logic [31:0]   hold_npc;

    logic accept;
    logic push;
    logic pop;
    logic is_hlt;

    // A pending discard means a stale request is still in flight, so no new one may go out.
    assign imem_req  = (state == FETCH) && !discard && (q_count < FULL);
    assign imem_addr = fetch_pc;

    assign id_valid = (q_count != '0);
    assign id_instr = id_valid ? q_instr[head] : hold_instr;
    assign id_npc   = id_valid ? q_npc[head]   : hold_npc;

    always_comb begin
        accept = imem_req && imem_ready;
        push   = imem_rvalid && (state == WAIT) && !redirect_valid;
        pop    = id_valid && id_ready && !redirect_valid;
        is_hlt = (imem_rdata[31:26] == OP_HLT);
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            req_pc     <= 32'h0;
            state      <= FETCH;
            discard    <= 1'b0;
            q_count    <= '0;
            head       <= '0;
            tail       <= '0;
            hold_instr <= 32'h0;
            hold_npc   <= 32'h0;
        end else begin
            hold_instr <= id_instr;
            hold_npc   <= id_npc;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                state    <= FETCH;
                q_count  <= '0;
                head     <= '0;
                tail     <= '0;
                // A response landing in this very cycle retires the in-flight request.
                discard  <= accept
                            || ((state == WAIT) && !imem_rvalid)
                            || (discard && !imem_rvalid);
            end else begin
                if (accept) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + 32'd1;
                    state    <= WAIT;
                end
                if (discard && imem_rvalid) begin
                    discard <= 1'b0;
                end
                if (push) begin
                    tail  <= tail + 1'b1;
                    state <= is_hlt ? HALTED : FETCH;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                case ({push, pop})
                    2'b10:   q_count <= q_count + 1'b1;
                    2'b01:   q_count <= q_count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst && push) begin
            q_instr[tail] <= imem_rdata;
            q_npc[tail]   <= req_pc + 32'd1;
        end
    end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: a one-outstanding memory model plus a program-order model of
// what decode must see (mem[pc] with npc=pc+1, restarting at each redirect, stopping after hlt).
module tb_mips_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_npc;
    logic        id_ready;
    logic [$clog2(DEPTH):0] q_count;

    always #5 clk1 = ~clk1;

    mips_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk1           (clk1),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_npc         (id_npc),
        .id_ready       (id_ready),
        .q_count        (q_count)
    );

    int n_vec = 0;
    int n_err = 0;

    bit          pending = 1'b0;
    logic [31:0] paddr   = 32'h0;
    int          cnt     = 0;
    int          lat     = 0;
    bit          lat_rand = 1'b0;
    bit          rdy_rand = 1'b0;
    bit          halt_en  = 1'b0;
    bit          idr      = 1'b1;
    bit          idr_rand = 1'b0;

    logic [31:0] exp_pc = 32'h0;
    bit          model_halted = 1'b0;
    int          consumed = 0;
    logic [31:0] log_instr[$];
    logic [31:0] log_npc[$];
    logic [31:0] acc_log[$];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (halt_en && a == 32'd3) return 32'hFC00_0000;
        return {6'b0, a[23:0], 2'b00};
    endfunction

    function automatic logic [31:0] logI(input int i);
        return (i < log_instr.size()) ? log_instr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] logN(input int i);
        return (i < log_npc.size()) ? log_npc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] accA(input int i);
        return (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearLogs();
        log_instr.delete();
        log_npc.delete();
        acc_log.delete();
    endtask

    // One clock cycle: drive inputs at the falling edge, check, then let the rising edge happen.
    task automatic applyStimulus(input bit rst_in, input bit redir, input logic [31:0] rpc);
        bit          delivered;
        bit          accepted;
        bit          consume;
        logic [31:0] want;
        logic [31:0] addr_s;
        rst            = rst_in;
        redirect_valid = redir;
        redirect_pc    = rpc;
        delivered      = pending && (cnt == 0);
        imem_rvalid    = delivered;
        imem_rdata     = delivered ? memWord(paddr) : $urandom;
        imem_ready     = !rst_in && !pending && (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        id_ready       = idr_rand ? 1'($urandom_range(0, 1)) : idr;
        #1;
        if (!rst_in) begin
            checkOutput("valid_vs_count", 32'(id_valid), 32'(q_count != 0));
            checkOutput("count_bound", 32'(q_count <= DEPTH), 1);
            if (q_count == DEPTH) checkOutput("req_when_full", 32'(imem_req), 0);
            if (model_halted) begin
                checkOutput("halted_empty", 32'(id_valid), 0);
                checkOutput("halted_req", 32'(imem_req), 0);
            end
        end
        consume = !rst_in && !redir && (id_valid === 1'b1) && id_ready;
        if (consume && !model_halted) begin
            want = memWord(exp_pc);
            checkOutput("id_instr", id_instr, want);
            checkOutput("id_npc", id_npc, exp_pc + 32'd1);
            log_instr.push_back(id_instr);
            log_npc.push_back(id_npc);
            consumed++;
            exp_pc = exp_pc + 32'd1;
            if (want[31:26] == 6'b111111) model_halted = 1'b1;
        end
        accepted = (imem_req === 1'b1) && imem_ready;
        addr_s   = imem_addr;
        @(posedge clk1);
        if (delivered) pending = 1'b0;
        else if (pending) cnt--;
        if (accepted) begin
            pending = 1'b1;
            paddr   = addr_s;
            cnt     = lat_rand ? int'($urandom_range(0, 3)) : lat;
            acc_log.push_back(addr_s);
        end
        if (rst_in) begin
            exp_pc       = 32'h0;
            model_halted = 1'b0;
        end else if (redir) begin
            exp_pc       = rpc;
            model_halted = 1'b0;
        end
        @(negedge clk1);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        clearLogs();
    endtask

    initial begin
        int          c0;
        int          r;
        logic [31:0] e0;
        logic [31:0] rpc;

        // Reset values and streaming at one instruction every two cycles.
        lat = 0; idr = 1'b1;
        doReset();
        checkOutput("rst_req", 32'(imem_req), 1);
        checkOutput("rst_valid", 32'(id_valid), 0);
        checkOutput("rst_count", 32'(q_count), 0);
        checkOutput("rst_instr", id_instr, 0);
        checkOutput("rst_npc", id_npc, 0);
        checkOutput("rst_addr", imem_addr, 0);
        c0 = consumed;
        repeat (20) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("stream_rate", 32'((consumed - c0) >= 9), 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stream_instr", logI(i), 32'(i * 4));
            checkOutput("stream_npc", logN(i), 32'(i + 1));
        end

        // Backpressure: queue saturates, then drains in order.
        idr = 1'b0;
        repeat (20) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("bp_count", 32'(q_count), DEPTH);
        checkOutput("bp_req", 32'(imem_req), 0);
        e0 = exp_pc; c0 = consumed; clearLogs();
        idr = 1'b1;
        repeat (8) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("drain_count", 32'((consumed - c0) >= 4), 1);
        for (int i = 0; i < 4; i++) checkOutput("drain_npc", logN(i), e0 + 32'(i + 1));

        // Redirect while the request to address 5 is outstanding.
        lat = 3;
        doReset();
        for (int i = 0; i < 100 && !(pending && paddr == 32'd5); i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("reach_addr5", paddr, 32'd5);
        clearLogs();
        applyStimulus(1'b0, 1'b1, 32'h40);
        checkOutput("redir_flush_count", 32'(q_count), 0);
        checkOutput("redir_flush_valid", 32'(id_valid), 0);
        for (int i = 0; i < 50 && log_instr.size() == 0; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("redir_instr", logI(0), 32'h100);
        checkOutput("redir_npc", logN(0), 32'h41);

        // Halt at address 3, then resume with a redirect to 0.
        halt_en = 1'b1; lat = 0;
        doReset();
        repeat (30) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("halt_nreq", 32'(acc_log.size()), 4);
        checkOutput("halt_last_addr", accA(3), 32'd3);
        checkOutput("halt_req", 32'(imem_req), 0);
        checkOutput("halt_instr", logI(3), 32'hFC00_0000);
        checkOutput("halt_npc", logN(3), 32'd4);
        applyStimulus(1'b0, 1'b1, 32'h0);
        clearLogs();
        for (int i = 0; i < 30 && log_instr.size() == 0; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("resume_addr", accA(0), 32'h0);
        checkOutput("resume_instr", logI(0), 32'h0);
        checkOutput("resume_npc", logN(0), 32'd1);

        // Push and pop together near full, then a full queue, then redirect with pop and rvalid.
        halt_en = 1'b0; lat = 2; idr = 1'b0;
        doReset();
        for (int i = 0; i < 60 && !(q_count == 3 && pending); i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("fill3", 32'(q_count), 3);
        for (int i = 0; i < 10 && cnt != 0; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        idr = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        idr = 1'b0;
        checkOutput("push_pop_count", 32'(q_count), 3);
        for (int i = 0; i < 20 && q_count != 3'(DEPTH); i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("full_count", 32'(q_count), DEPTH);
        checkOutput("full_req", 32'(imem_req), 0);
        idr = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        idr = 1'b0;
        for (int i = 0; i < 20 && !(pending && cnt == 0); i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("pre_redir_valid", 32'(id_valid), 1);
        idr = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h100);
        idr = 1'b0;
        checkOutput("redir_pop_rsp_count", 32'(q_count), 0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("redir_no_push", 32'(q_count), 0);

        // Wrap-around of the fetch address.
        idr = 1'b1; lat = 0;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
        clearLogs();
        for (int i = 0; i < 40 && (log_instr.size() == 0 || acc_log.size() < 2); i++)
            applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("wrap_addr0", accA(0), 32'hFFFF_FFFF);
        checkOutput("wrap_addr1", accA(1), 32'h0);
        checkOutput("wrap_instr", logI(0), 32'h03FF_FFFC);
        checkOutput("wrap_npc", logN(0), 32'h0);

        // Random traffic: memory stalls, decode stalls, redirects, resets and halts.
        halt_en = 1'b1; lat_rand = 1'b1; rdy_rand = 1'b1; idr_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 12));
            if (r == 0)      applyStimulus(1'b1, 1'b0, 32'h0);
            else if (r < 5)  applyStimulus(1'b0, 1'b1, rpc);
            else             applyStimulus(1'b0, 1'b0, 32'h0);
        end
        checkOutput("random_progress", 32'(consumed > 100), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
